// File: rtl/serial_code_lock.sv
// Serial unlock controller: shifts in a CODE_LEN-bit code MSB first, compares it against a
// programmable code register, counts consecutive failures and enforces a timed lockout.
// Optional inter-bit timeout is built only when CODE_LOCK_TIMEOUT_EN is defined.
module serial_code_lock #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0]   RESET_CODE     = CODE_LEN'(4'b1011),
    parameter int                    MAX_FAIL       = 3,
    parameter int                    LOCKOUT_CYCLES = 16,
    parameter int                    TIMEOUT_CYCLES = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ser_val,
    input  logic                            ser_data,
    input  logic                            cfg_we,
    input  logic [CODE_LEN-1:0]             cfg_code,
    output logic                            output_val,
    output logic                            unlock,
    output logic                            fail,
    output logic                            locked_out,
    output logic                            busy,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int BW = $clog2(CODE_LEN + 1);
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    if (CODE_LEN < 1) begin : g_chk_code_len
        $error("serial_code_lock: CODE_LEN must be >= 1");
    end
    if (MAX_FAIL < 1) begin : g_chk_max_fail
        $error("serial_code_lock: MAX_FAIL must be >= 1");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_chk_lockout
        $error("serial_code_lock: LOCKOUT_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("serial_code_lock: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [CODE_LEN-1:0] shift_q,    shift_d;
    logic [CODE_LEN-1:0] code_q,     code_d;
    logic [BW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [FW-1:0]       fail_cnt_q, fail_cnt_d;
    logic [LW-1:0]       lock_cnt_q, lock_cnt_d;
    logic                verdict_ok;

`ifdef CODE_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]       to_cnt_q,   to_cnt_d;
    logic                timeout_q,  timeout_d;

    // A timed-out attempt must fail even if the partial shift happens to equal the code.
    assign verdict_ok = (shift_q == code_q) && !timeout_q;
`else
    assign verdict_ok = (shift_q == code_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            code_q     <= RESET_CODE;
            bit_cnt_q  <= '0;
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
`ifdef CODE_LOCK_TIMEOUT_EN
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            code_q     <= code_d;
            bit_cnt_q  <= bit_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            lock_cnt_q <= lock_cnt_d;
`ifdef CODE_LOCK_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        code_d     = code_q;
        bit_cnt_d  = bit_cnt_q;
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
`ifdef CODE_LOCK_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef CODE_LOCK_TIMEOUT_EN
                to_cnt_d  = '0;
                timeout_d = 1'b0;
`endif
                // Programming takes priority; a simultaneous code bit is dropped.
                if (cfg_we) begin
                    code_d = cfg_code;
                end else if (ser_val) begin
                    shift_d   = CODE_LEN'(ser_data);
                    bit_cnt_d = BW'(1);
                    state_d   = (CODE_LEN == 1) ? RESULT : COLLECT;
                end
            end
            COLLECT: begin
                if (ser_val) begin
                    shift_d   = CODE_LEN'({shift_q, ser_data});
                    bit_cnt_d = bit_cnt_q + BW'(1);
`ifdef CODE_LOCK_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                    if (bit_cnt_q + BW'(1) == BW'(CODE_LEN)) begin
                        state_d = RESULT;
                    end
                end
`ifdef CODE_LOCK_TIMEOUT_EN
                else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    to_cnt_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = RESULT;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
`endif
            end
            RESULT: begin
                bit_cnt_d = '0;
                if (verdict_ok) begin
                    fail_cnt_d = '0;
                    state_d    = IDLE;
                end else if (fail_cnt_q == FW'(MAX_FAIL - 1)) begin
                    fail_cnt_d = FW'(MAX_FAIL);
                    lock_cnt_d = '0;
                    state_d    = LOCKOUT;
                end else begin
                    fail_cnt_d = fail_cnt_q + FW'(1);
                    state_d    = IDLE;
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == LW'(LOCKOUT_CYCLES - 1)) begin
                    lock_cnt_d = '0;
                    fail_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign output_val = (state_q == RESULT);
    assign unlock     = (state_q == RESULT) && verdict_ok;
    assign fail       = (state_q == RESULT) && !verdict_ok;
    assign locked_out = (state_q == LOCKOUT);
    assign busy       = (state_q != IDLE);
    assign fail_cnt   = fail_cnt_q;

endmodule
